// File: rtl/wb16_ext_bus_pkg.sv
// Shared types and constants for the Wishbone-to-external-async-bus slave.
package wb16_ext_bus_pkg;

  // Width of the phase and wait counters; sized to hold any legal TIMEOUT.
  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STRB,
    S_HOLD,
    S_DONE
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with synchronous active-low reset to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage shift register bringing d_i into the clk_i domain.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/wb16_ext_bus.sv
// Wishbone 16-bit slave running one timed setup/strobe/hold cycle on an
// external asynchronous 16-bit bus per WB access, with ready extension
// and timeout error.
module wb16_ext_bus
  import wb16_ext_bus_pkg::*;
#(
  parameter int unsigned AWIDTH  = 16,
  parameter int unsigned SETUP   = 1,
  parameter int unsigned STROBE  = 3,
  parameter int unsigned HOLD    = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              wb_clk,
  input  logic              wb_rst_n,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [1:0]        wb_sel_i,
  input  logic [AWIDTH-1:0] wb_adr_i,
  input  logic [15:0]       wb_dat_i,
  output logic [15:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic [AWIDTH-2:0] ext_adr_o,
  output logic [15:0]       ext_dat_o,
  input  logic [15:0]       ext_dat_i,
  output logic              ext_dat_oe,
  output logic              ext_cs_n,
  output logic              ext_oe_n,
  output logic              ext_we_n,
  output logic [1:0]        ext_be_n,
  input  logic              ext_rdy_i
);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP - 1);
  localparam logic [CNT_W-1:0] STRB_LAST  = CNT_W'(STROBE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((HOLD == 0) ? 0 : HOLD - 1);
  localparam logic [CNT_W-1:0] TO_LIM     = CNT_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              err_q, err_d;
  logic              abort_q, abort_d;
  logic              we_q, we_d;
  logic [AWIDTH-2:0] adr_q, adr_d;
  logic [1:0]        be_n_q, be_n_d;
  logic [15:0]       dat_q, dat_d;
  logic              dat_oe_q, dat_oe_d;
  logic              cs_n_q, cs_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic [15:0]       rdat_q, rdat_d;
  logic              ack_q, ack_d;
  logic              werr_q, werr_d;
  logic              go_done, done_err;
  logic              live;
  logic              rdy_s;
  logic              unused_adr0;

  // Byte-address bit 0 has no meaning on a halfword bus.
  assign unused_adr0 = wb_adr_i[0];

  sync_2ff u_rdy_sync (
    .clk_i  (wb_clk),
    .rst_ni (wb_rst_n),
    .d_i    (ext_rdy_i),
    .q_o    (rdy_s)
  );

  // Master still owns this transaction: no cyc drop seen so far or now.
  assign live = !abort_q && wb_cyc_i;

  // Next-state and next-output logic; every ext_* output is registered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    err_d    = err_q;
    abort_d  = abort_q;
    we_d     = we_q;
    adr_d    = adr_q;
    be_n_d   = be_n_q;
    dat_d    = dat_q;
    dat_oe_d = dat_oe_q;
    cs_n_d   = cs_n_q;
    oe_n_d   = oe_n_q;
    we_n_d   = we_n_q;
    rdat_d   = rdat_q;
    ack_d    = 1'b0;
    werr_d   = 1'b0;
    go_done  = 1'b0;
    done_err = 1'b0;

    if (state_q != S_IDLE && !wb_cyc_i) begin
      abort_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          state_d  = S_SETUP;
          cnt_d    = '0;
          wait_d   = '0;
          err_d    = 1'b0;
          abort_d  = 1'b0;
          we_d     = wb_we_i;
          adr_d    = wb_adr_i[AWIDTH-1:1];
          be_n_d   = ~wb_sel_i;
          dat_d    = wb_dat_i;
          dat_oe_d = wb_we_i;
          cs_n_d   = 1'b0;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_STRB;
          cnt_d   = '0;
          oe_n_d  = we_q;
          we_n_d  = !we_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STRB: begin
        if (cnt_q != STRB_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (rdy_s || wait_q == TO_LIM) begin
          oe_n_d = 1'b1;
          we_n_d = 1'b1;
          cnt_d  = '0;
          err_d  = !rdy_s;
          if (!we_q && rdy_s && live) begin
            rdat_d = ext_dat_i;
          end
          if (HOLD == 0) begin
            go_done  = 1'b1;
            done_err = !rdy_s;
          end else begin
            state_d = S_HOLD;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          go_done  = 1'b1;
          done_err = err_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (go_done) begin
      state_d  = S_DONE;
      cs_n_d   = 1'b1;
      be_n_d   = '1;
      dat_oe_d = 1'b0;
      ack_d    = live && !done_err;
      werr_d   = live && done_err;
    end
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wait_q   <= '0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      be_n_q   <= '1;
      dat_q    <= '0;
      dat_oe_q <= 1'b0;
      cs_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      rdat_q   <= '0;
      ack_q    <= 1'b0;
      werr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      err_q    <= err_d;
      abort_q  <= abort_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      be_n_q   <= be_n_d;
      dat_q    <= dat_d;
      dat_oe_q <= dat_oe_d;
      cs_n_q   <= cs_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      rdat_q   <= rdat_d;
      ack_q    <= ack_d;
      werr_q   <= werr_d;
    end
  end

  assign wb_dat_o   = rdat_q;
  assign wb_ack_o   = ack_q;
  assign wb_err_o   = werr_q;
  assign ext_adr_o  = adr_q;
  assign ext_dat_o  = dat_q;
  assign ext_dat_oe = dat_oe_q;
  assign ext_cs_n   = cs_n_q;
  assign ext_oe_n   = oe_n_q;
  assign ext_we_n   = we_n_q;
  assign ext_be_n   = be_n_q;

endmodule

// File: tb/tb_wb16_ext_bus.sv
// Directed self-checking bench for wb16_ext_bus: vector table of single
// accesses plus hand sequences for back-to-back, ready stretch, timeout,
// reset during strobe and cyc drop.
module tb_wb16_ext_bus;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, cyc2 = 1'b0, stb = 1'b0, we = 1'b0;
  logic [1:0]  sel = 2'b00;
  logic [15:0] adr = '0, wdat = '0, ext_din = '0;
  logic        rdy = 1'b1, rdy2 = 1'b1;

  logic [15:0] wb_dat_o, ext_dat_o;
  logic        wb_ack_o, wb_err_o, ext_dat_oe, ext_cs_n, ext_oe_n, ext_we_n;
  logic [14:0] ext_adr_o;
  logic [1:0]  ext_be_n;

  logic [15:0] t_dat_o, t_ext_dat_o;
  logic        t_ack, t_err, t_dat_oe, t_cs_n, t_oe_n, t_we_n;
  logic [14:0] t_ext_adr;
  logic [1:0]  t_be_n;

  int n_chk = 0;
  int n_fail = 0;
  int cnum = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cnum <= cnum + 1;

  wb16_ext_bus u_dut (
    .wb_clk(clk), .wb_rst_n(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_we_i(we), .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .ext_adr_o(ext_adr_o), .ext_dat_o(ext_dat_o), .ext_dat_i(ext_din),
    .ext_dat_oe(ext_dat_oe), .ext_cs_n(ext_cs_n), .ext_oe_n(ext_oe_n),
    .ext_we_n(ext_we_n), .ext_be_n(ext_be_n), .ext_rdy_i(rdy)
  );

  wb16_ext_bus #(.TIMEOUT(4)) u_to (
    .wb_clk(clk), .wb_rst_n(rst_n), .wb_cyc_i(cyc2), .wb_stb_i(stb),
    .wb_we_i(we), .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_dat_o(t_dat_o), .wb_ack_o(t_ack), .wb_err_o(t_err),
    .ext_adr_o(t_ext_adr), .ext_dat_o(t_ext_dat_o), .ext_dat_i(ext_din),
    .ext_dat_oe(t_dat_oe), .ext_cs_n(t_cs_n), .ext_oe_n(t_oe_n),
    .ext_we_n(t_we_n), .ext_be_n(t_be_n), .ext_rdy_i(rdy2)
  );

  typedef struct {
    logic [15:0] adr;
    logic [15:0] dat;
    logic [15:0] din;
    logic [1:0]  sel;
    logic        we;
    logic [14:0] x_adr;
    logic [1:0]  x_be;
    int          x_oe;
    int          x_we;
    int          x_doe;
    logic [15:0] x_rd;
  } vec_t;

  vec_t tbl[5];

  // Per-transaction observations on the main instance
  int          m_oe, m_we, m_doe, m_cs, m_ovl, m_acks, m_errs, m_lat, m_ack_cyc;
  logic [14:0] m_adr;
  logic [1:0]  m_be;
  logic [15:0] m_dato;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},    {31'd0, wb_ack_o},   32'd0);
    check({tag, "_err"},    {31'd0, wb_err_o},   32'd0);
    check({tag, "_wbdat"},  {16'd0, wb_dat_o},   32'd0);
    check({tag, "_cs_n"},   {31'd0, ext_cs_n},   32'd1);
    check({tag, "_oe_n"},   {31'd0, ext_oe_n},   32'd1);
    check({tag, "_we_n"},   {31'd0, ext_we_n},   32'd1);
    check({tag, "_be_n"},   {30'd0, ext_be_n},   32'd3);
    check({tag, "_dat_oe"}, {31'd0, ext_dat_oe}, 32'd0);
    check({tag, "_adr"},    {17'd0, ext_adr_o},  32'd0);
    check({tag, "_extdat"}, {16'd0, ext_dat_o},  32'd0);
  endtask

  // Issue one request on the main instance, observing at each negedge until
  // ack/err. rdy_after>0 raises ext_rdy_i once that many strobe cycles seen.
  task automatic run_req(input logic [15:0] a, input logic [15:0] d, input logic [1:0] s,
                         input logic w, input logic release_after, input int rdy_after);
    @(posedge clk); #1;
    adr = a; wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    m_oe = 0; m_we = 0; m_doe = 0; m_cs = 0; m_ovl = 0; m_acks = 0; m_errs = 0;
    m_lat = -1; m_ack_cyc = -1; m_adr = '0; m_be = '0; m_dato = '0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!ext_oe_n) m_oe++;
      if (!ext_we_n) m_we++;
      if (ext_dat_oe) m_doe++;
      if (!ext_cs_n) m_cs++;
      if (!ext_oe_n && !ext_we_n) m_ovl++;
      if (!ext_oe_n || !ext_we_n) begin
        m_adr = ext_adr_o; m_be = ext_be_n; m_dato = ext_dat_o;
      end
      if (rdy_after > 0 && m_oe == rdy_after) rdy = 1'b1;
      if (wb_ack_o || wb_err_o) begin
        m_lat = k; m_ack_cyc = cnum;
        if (wb_ack_o) m_acks++;
        if (wb_err_o) m_errs++;
        break;
      end
    end
    if (release_after) begin
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      check("ack_one_cycle", {31'd0, wb_ack_o}, 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          a1, c1, ovl, n_oe, n_ack, n_err, err_k, n_cs;
    logic        t_ok, found;
    logic [15:0] prev;

    tbl[0] = '{16'h0012, 16'hA5C3, 16'h0000, 2'b11, 1'b1, 15'h0009, 2'b00, 0, 3, 5, 16'h0000};
    tbl[1] = '{16'h0034, 16'h0000, 16'h1234, 2'b11, 1'b0, 15'h001A, 2'b00, 3, 0, 0, 16'h1234};
    tbl[2] = '{16'hFFFF, 16'h00FF, 16'h0000, 2'b01, 1'b1, 15'h7FFF, 2'b10, 0, 3, 5, 16'h1234};
    tbl[3] = '{16'h0100, 16'h0000, 16'hBEEF, 2'b10, 1'b0, 15'h0080, 2'b01, 3, 0, 0, 16'hBEEF};
    tbl[4] = '{16'h0002, 16'h1111, 16'h0000, 2'b00, 1'b1, 15'h0001, 2'b11, 0, 3, 5, 16'hBEEF};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Single accesses from the vector table
    for (int i = 0; i < 5; i++) begin
      ext_din = tbl[i].din;
      run_req(tbl[i].adr, tbl[i].dat, tbl[i].sel, tbl[i].we, 1'b1, 0);
      check($sformatf("v%0d_latency", i), m_lat, 32'd6);
      check($sformatf("v%0d_acks", i), m_acks, 32'd1);
      check($sformatf("v%0d_errs", i), m_errs, 32'd0);
      check($sformatf("v%0d_ext_adr", i), {17'd0, m_adr}, {17'd0, tbl[i].x_adr});
      check($sformatf("v%0d_be_n", i), {30'd0, m_be}, {30'd0, tbl[i].x_be});
      check($sformatf("v%0d_oe_low", i), m_oe, tbl[i].x_oe);
      check($sformatf("v%0d_we_low", i), m_we, tbl[i].x_we);
      check($sformatf("v%0d_dat_oe", i), m_doe, tbl[i].x_doe);
      check($sformatf("v%0d_cs_low", i), m_cs, 32'd5);
      check($sformatf("v%0d_wb_dat", i), {16'd0, wb_dat_o}, {16'd0, tbl[i].x_rd});
      if (tbl[i].we) check($sformatf("v%0d_ext_dat", i), {16'd0, m_dato}, {16'd0, tbl[i].dat});
    end

    // Back-to-back halves of a 32-bit read at 0x40
    ext_din = 16'hCAFE;
    run_req(16'h0040, 16'h0000, 2'b11, 1'b0, 1'b0, 0);
    a1 = {17'd0, m_adr}; c1 = m_ack_cyc; ovl = m_ovl;
    check("b2b_first_rdata", {16'd0, wb_dat_o}, 32'h0000CAFE);
    ext_din = 16'hF00D;
    run_req(16'h0042, 16'h0000, 2'b11, 1'b0, 1'b1, 0);
    ovl += m_ovl;
    check("b2b_adr_first", a1, 32'h20);
    check("b2b_adr_second", {17'd0, m_adr}, 32'h21);
    check("b2b_ack_gap", m_ack_cyc - c1, 32'd7);
    check("b2b_no_overlap", ovl, 32'd0);
    check("b2b_second_rdata", {16'd0, wb_dat_o}, 32'h0000F00D);

    // Ready held low 10 cycles past the minimum strobe
    rdy = 1'b0;
    repeat (4) @(posedge clk);
    ext_din = 16'h7E57;
    run_req(16'h0080, 16'h0000, 2'b11, 1'b0, 1'b1, 13);
    check("rdy_oe_low", m_oe, 32'd15);
    check("rdy_latency", m_lat, 32'd18);
    check("rdy_acks", m_acks, 32'd1);
    check("rdy_rdata", {16'd0, wb_dat_o}, 32'h00007E57);

    // Timeout instance: one good read, then ready stuck low
    @(posedge clk); #1;
    adr = 16'h0010; we = 1'b0; sel = 2'b11; ext_din = 16'h3C3C; cyc2 = 1'b1; stb = 1'b1;
    t_ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (t_ack || t_err) begin t_ok = t_ack; break; end
    end
    cyc2 = 1'b0; stb = 1'b0;
    check("to_good_ack", {31'd0, t_ok}, 32'd1);
    check("to_good_rdata", {16'd0, t_dat_o}, 32'h00003C3C);
    rdy2 = 1'b0;
    repeat (4) @(posedge clk); #1;
    adr = 16'h0020; ext_din = 16'hDEAD; cyc2 = 1'b1; stb = 1'b1;
    n_oe = 0; n_ack = 0; n_err = 0; err_k = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!t_oe_n) n_oe++;
      if (t_ack) n_ack++;
      if (t_err) begin
        n_err++;
        if (err_k < 0) err_k = k;
        cyc2 = 1'b0; stb = 1'b0;
      end
    end
    cyc2 = 1'b0; stb = 1'b0; rdy2 = 1'b1;
    check("to_oe_low", n_oe, 32'd7);
    check("to_err_pulses", n_err, 32'd1);
    check("to_acks", n_ack, 32'd0);
    check("to_err_latency", err_k, 32'd10);
    check("to_rdata_kept", {16'd0, t_dat_o}, 32'h00003C3C);

    // Reset asserted during the strobe
    @(posedge clk); #1;
    adr = 16'h0AAA; wdat = 16'h5555; sel = 2'b11; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!ext_we_n) begin found = 1'b1; break; end
    end
    check("rst_reached_strobe", {31'd0, found}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    ext_din = 16'h0BAD;
    run_req(16'h0030, 16'h0000, 2'b11, 1'b0, 1'b1, 0);
    check("post_rst_latency", m_lat, 32'd6);
    check("post_rst_rdata", {16'd0, wb_dat_o}, 32'h00000BAD);

    // cyc dropped during SETUP: full external cycle, no ack, data kept
    prev = wb_dat_o;
    @(posedge clk); #1;
    adr = 16'h0066; sel = 2'b11; we = 1'b0; ext_din = 16'h9999; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    n_oe = 0; n_ack = 0; n_err = 0; n_cs = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (!ext_oe_n) n_oe++;
      if (!ext_cs_n) n_cs++;
      if (wb_ack_o) n_ack++;
      if (wb_err_o) n_err++;
    end
    check("drop_oe_low", n_oe, 32'd3);
    check("drop_cs_low", n_cs, 32'd5);
    check("drop_no_ack", n_ack, 32'd0);
    check("drop_no_err", n_err, 32'd0);
    check("drop_rdata_kept", {16'd0, wb_dat_o}, {16'd0, prev});
    run_req(16'h0068, 16'h4321, 2'b11, 1'b1, 1'b1, 0);
    check("post_drop_latency", m_lat, 32'd6);
    check("post_drop_rdata_kept", {16'd0, wb_dat_o}, {16'd0, prev});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
